doa_tracker: RTL and testbench

- Consumes the per-frame direction-of-arrival result of the beam-weighting stage (done pulse, beam number, DOA in degrees).
- Produces a smoothed, outlier-filtered DOA for the display and control logic.
- Keeps a circular history of the last DEPTH accepted estimates with a running sum and rejects isolated jumps.
- Re-acquires after a confirmed move or after the estimate stream stops.

---
 rtl/doa_pkg.sv | 21 ++
 rtl/doa_if.sv | 25 ++
 rtl/doa_ring_avg.sv | 72 +++++++
 rtl/doa_tracker.sv | 169 ++++++++++++++++
 tb/tb_doa_tracker.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/doa_pkg.sv
// Shared widths, limits, tracker states and the DOA distance helper.
package doa_pkg;

  localparam int DOA_W   = 8;
  localparam int BNUM_W  = 6;
  localparam int MAX_DOA = 180;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    TRACK = 2'd2
  } state_e;

  // |a - b| taken on 9-bit signed operands so 0..255 inputs never wrap.
  function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? $unsigned(-d) : $unsigned(d);
  endfunction

endpackage

// File: rtl/doa_if.sv
// Estimate-in / smoothed-DOA-out bundle between the beam stage and the tracker.
interface doa_if;
  import doa_pkg::*;

  logic              done;
  logic [BNUM_W-1:0] bnum;
  logic [DOA_W-1:0]  doa;
  logic [DOA_W-1:0]  avg_doa;
  logic              avg_valid;
  logic [BNUM_W-1:0] last_bnum;
  logic [5:0]        fill_cnt;
  logic              upd;
  logic              rej;
  logic              flushed;

  modport master (
    output done, bnum, doa,
    input  avg_doa, avg_valid, last_bnum, fill_cnt, upd, rej, flushed
  );

  modport slave (
    input  done, bnum, doa,
    output avg_doa, avg_valid, last_bnum, fill_cnt, upd, rej, flushed
  );
endinterface

// File: rtl/doa_ring_avg.sv
// Circular history of accepted DOA samples with a running sum and rounded mean.
module doa_ring_avg
  import doa_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             wr_i,
  input  logic             rpl_i,
  input  logic [DOA_W-1:0] din_i,
  output logic [DOA_W-1:0] avg_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = DOA_W + AW;

  logic [DOA_W-1:0] mem_q [DEPTH];
  logic [DOA_W-1:0] old_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, wr_addr;
  logic [SW-1:0]    sum_q, sum_d, rnd;
  logic             we;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    sum_d    = sum_q;
    wr_addr  = wr_ptr_q;
    we       = 1'b0;
    if (clr_i) begin
      wr_ptr_d = '0;
      sum_d    = '0;
    end else if (load_i) begin
      we       = 1'b1;
      wr_addr  = '0;
      wr_ptr_d = AW'(1);
      sum_d    = SW'(din_i);
    end else if (wr_i) begin
      we       = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      sum_d    = sum_q + SW'(din_i);
    end else if (rpl_i) begin
      we       = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      sum_d    = sum_q - SW'(old_q) + SW'(din_i);
    end
  end

  // Mean of the post-update sum, so the caller can register it alongside.
  always_comb begin
    rnd   = sum_d + SW'(DEPTH / 2);
    avg_o = rnd[SW-1:AW];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      sum_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      sum_q    <= sum_d;
    end
  end

  // Prefetch the entry at the next write pointer: it is the oldest once full.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_addr] <= din_i;
    old_q <= mem_q[wr_ptr_d];
  end

endmodule

// File: rtl/doa_tracker.sv
// Smoothing, outlier rejection and timeout flush for per-frame DOA estimates.
module doa_tracker
  import doa_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int JUMP_THR = 20,
  parameter int CONFIRM  = 3,
  parameter int TIMEOUT  = 5000000
) (
  input  logic clk,
  input  logic reset,
  doa_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int JW    = $clog2(CONFIRM + 1);

  logic              s1_valid_q, s1_valid_d;
  logic [DOA_W-1:0]  s1_doa_q, s1_doa_d;
  logic [BNUM_W-1:0] s1_bnum_q, s1_bnum_d;
  logic              drop_q, drop_d;
  logic [1:0]        guard_q, guard_d;
  state_e            state_q, state_d;
  logic [5:0]        fill_q, fill_d;
  logic [JW-1:0]     jump_q, jump_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic [DOA_W-1:0]  avg_q, avg_d, avg_raw, ring_avg;
  logic              avg_valid_q, avg_valid_d;
  logic [BNUM_W-1:0] last_bnum_q, last_bnum_d;
  logic              upd_q, upd_d, rej_q, rej_d, flushed_q, flushed_d;
  logic              use_mean, hold, take, expire;
  logic              ring_clr, ring_load, ring_wr, ring_rpl;

  doa_ring_avg #(.DEPTH(DEPTH)) u_ring (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (ring_clr),
    .load_i (ring_load),
    .wr_i   (ring_wr),
    .rpl_i  (ring_rpl),
    .din_i  (s1_doa_q),
    .avg_o  (ring_avg)
  );

  assign expire = (fill_q != 6'd0) && (tmo_q >= CNT_W'(TIMEOUT - 1));
  assign take   = bus.done && (guard_q == 2'd0);

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    jump_d      = jump_q;
    avg_valid_d = avg_valid_q;
    last_bnum_d = last_bnum_q;
    avg_raw     = avg_q;
    use_mean    = 1'b0;
    upd_d       = 1'b0;
    rej_d       = drop_q;
    flushed_d   = 1'b0;
    ring_clr    = 1'b0;
    ring_load   = 1'b0;
    ring_wr     = 1'b0;
    ring_rpl    = 1'b0;
    hold        = 1'b0;
    tmo_d       = (tmo_q == CNT_W'(TIMEOUT)) ? tmo_q : tmo_q + CNT_W'(1);

    // A pending sample waits one slot behind a timeout flush.
    if (expire) begin
      state_d     = EMPTY;
      fill_d      = 6'd0;
      avg_valid_d = 1'b0;
      jump_d      = '0;
      ring_clr    = 1'b1;
      flushed_d   = 1'b1;
      hold        = s1_valid_q;
    end else if (s1_valid_q) begin
      if (s1_doa_q > DOA_W'(MAX_DOA)) begin
        rej_d = 1'b1;
      end else begin
        tmo_d = '0;
        if (state_q != TRACK) begin
          ring_wr     = 1'b1;
          fill_d      = fill_q + 6'd1;
          last_bnum_d = s1_bnum_q;
          upd_d       = 1'b1;
          if (fill_q == 6'(DEPTH - 1)) begin
            state_d     = TRACK;
            avg_valid_d = 1'b1;
            use_mean    = 1'b1;
          end else begin
            state_d = FILL;
            avg_raw = s1_doa_q;
          end
        end else if (abs_diff(s1_doa_q, avg_q) <= 9'(JUMP_THR)) begin
          ring_rpl    = 1'b1;
          jump_d      = '0;
          use_mean    = 1'b1;
          upd_d       = 1'b1;
          last_bnum_d = s1_bnum_q;
        end else if (jump_q == JW'(CONFIRM - 1)) begin
          ring_load   = 1'b1;
          fill_d      = 6'd1;
          state_d     = FILL;
          avg_raw     = s1_doa_q;
          avg_valid_d = 1'b0;
          jump_d      = '0;
          flushed_d   = 1'b1;
          upd_d       = 1'b1;
          last_bnum_d = s1_bnum_q;
        end else begin
          jump_d = jump_q + JW'(1);
          rej_d  = 1'b1;
        end
      end
    end

    s1_valid_d = hold ? s1_valid_q : take;
    s1_doa_d   = (take && !hold) ? bus.doa  : s1_doa_q;
    s1_bnum_d  = (take && !hold) ? bus.bnum : s1_bnum_q;
    drop_d     = bus.done && (guard_q != 2'd0);
    guard_d    = take ? 2'd2 : ((guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0);
  end

  assign avg_d = use_mean ? ring_avg : avg_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_doa_q    <= '0;
      s1_bnum_q   <= '0;
      drop_q      <= 1'b0;
      guard_q     <= 2'd0;
      state_q     <= EMPTY;
      fill_q      <= 6'd0;
      jump_q      <= '0;
      tmo_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      last_bnum_q <= '0;
      upd_q       <= 1'b0;
      rej_q       <= 1'b0;
      flushed_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_doa_q    <= s1_doa_d;
      s1_bnum_q   <= s1_bnum_d;
      drop_q      <= drop_d;
      guard_q     <= guard_d;
      state_q     <= state_d;
      fill_q      <= fill_d;
      jump_q      <= jump_d;
      tmo_q       <= tmo_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      last_bnum_q <= last_bnum_d;
      upd_q       <= upd_d;
      rej_q       <= rej_d;
      flushed_q   <= flushed_d;
    end
  end

  assign bus.avg_doa   = avg_q;
  assign bus.avg_valid = avg_valid_q;
  assign bus.last_bnum = last_bnum_q;
  assign bus.fill_cnt  = fill_q;
  assign bus.upd       = upd_q;
  assign bus.rej       = rej_q;
  assign bus.flushed   = flushed_q;

endmodule

// File: tb/tb_doa_tracker.sv
// Directed vectors plus hand sequences for spacing, timeout and mid-flight reset.
module tb_doa_tracker;

  localparam int TMO = 1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  doa_if bus ();

  doa_tracker #(.DEPTH(8), .JUMP_THR(20), .CONFIRM(3), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic [7:0] doa;
    logic [5:0] bnum;
    logic       upd, rej, fl;
    logic [7:0] avg;
    logic       vld;
    logic [5:0] fill;
    logic [5:0] lb;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, input int doa, input int bnum,
                              input logic upd, input logic rej, input logic fl,
                              input int avg, input logic vld, input int fill, input int lb);
    vec_t v;
    v.rst = rst; v.doa = 8'(doa); v.bnum = 6'(bnum);
    v.upd = upd; v.rej = rej; v.fl = fl;
    v.avg = 8'(avg); v.vld = vld; v.fill = 6'(fill); v.lb = 6'(lb);
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic upd, input logic rej, input logic fl,
                         input int avg, input logic vld, input int fill, input int lb);
    chk({tag, " upd"}, int'(bus.upd), int'(upd));
    chk({tag, " rej"}, int'(bus.rej), int'(rej));
    chk({tag, " flushed"}, int'(bus.flushed), int'(fl));
    chk({tag, " avg_doa"}, int'(bus.avg_doa), avg);
    chk({tag, " avg_valid"}, int'(bus.avg_valid), int'(vld));
    chk({tag, " fill_cnt"}, int'(bus.fill_cnt), fill);
    chk({tag, " last_bnum"}, int'(bus.last_bnum), lb);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    bus.done = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_all({tag, " reset"}, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
  endtask

  // Returns on the negedge where this sample's outputs are visible.
  task automatic send(input int doa, input int bnum);
    @(negedge clk);
    bus.done = 1'b1;
    bus.doa  = 8'(doa);
    bus.bnum = 6'(bnum);
    @(negedge clk);
    bus.done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    bus.done = 1'b0;
    bus.doa  = '0;
    bus.bnum = '0;

    // Fill at 90, track toward 98, invalid and threshold boundaries.
    for (int i = 0; i < 8; i++) add(i == 0, 90, 5, 1, 0, 0, 90, i == 7, i + 1, 5);
    for (int k = 1; k <= 8; k++) add(0, 98, 7, 1, 0, 0, 90 + k, 1, 8, 7);
    add(0, 200,  8, 0, 1, 0,  98, 1, 8,  7);
    add(0, 118,  9, 1, 0, 0, 101, 1, 8,  9);
    add(0, 122, 10, 0, 1, 0, 101, 1, 8,  9);
    add(0,  80, 11, 0, 1, 0, 101, 1, 8,  9);
    add(0,  81, 12, 1, 0, 0,  98, 1, 8, 12);
    // Outliers, jump counter cleared, then confirmed move.
    for (int i = 0; i < 8; i++) add(i == 0, 90, 5, 1, 0, 0, 90, i == 7, i + 1, 5);
    add(0, 150,  9, 0, 1, 0,  90, 1, 8,  5);
    add(0, 150,  9, 0, 1, 0,  90, 1, 8,  5);
    add(0,  92, 10, 1, 0, 0,  90, 1, 8, 10);
    add(0, 150, 11, 0, 1, 0,  90, 1, 8, 10);
    add(0, 150, 11, 0, 1, 0,  90, 1, 8, 10);
    add(0, 150, 12, 1, 0, 1, 150, 0, 1, 12);
    add(0, 200, 13, 0, 1, 0, 150, 0, 1, 12);
    add(0,  30, 14, 1, 0, 0,  30, 0, 2, 14);

    do_reset("init");
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset($sformatf("v%0d", i));
      send(int'(tbl[i].doa), int'(tbl[i].bnum));
      chk_all($sformatf("v%0d", i), tbl[i].upd, tbl[i].rej, tbl[i].fl,
              int'(tbl[i].avg), tbl[i].vld, int'(tbl[i].fill), int'(tbl[i].lb));
      $display("vec %0d doa=%0d bnum=%0d -> avg=%0d fill=%0d upd=%0b rej=%0b fl=%0b",
               i, tbl[i].doa, tbl[i].bnum, bus.avg_doa, bus.fill_cnt, bus.upd, bus.rej, bus.flushed);
    end

    // Timeout flush after the stream stops.
    do_reset("tmo");
    for (int i = 0; i < 8; i++) send(90, 5);
    cyc = 0;
    while (cyc < 1200 && bus.flushed !== 1'b1) begin
      @(negedge clk);
      cyc++;
    end
    chk("tmo flushed seen", int'(bus.flushed === 1'b1), 1);
    chk("tmo window", int'(cyc >= TMO - 2 && cyc <= TMO + 2), 1);
    chk_all("tmo", 1'b0, 1'b0, 1'b1, 90, 1'b0, 0, 5);
    $display("timeout flush after %0d cycles", cyc);
    send(70, 3);
    chk_all("tmo refill", 1'b1, 1'b0, 1'b0, 70, 1'b0, 1, 3);

    // Back-to-back done: second one is dropped with a late rej.
    do_reset("gap");
    @(negedge clk);
    bus.done = 1'b1; bus.doa = 8'd90; bus.bnum = 6'd1;
    @(negedge clk);
    bus.doa = 8'd91; bus.bnum = 6'd2;
    @(negedge clk);
    bus.done = 1'b0;
    chk_all("gap first", 1'b1, 1'b0, 1'b0, 90, 1'b0, 1, 1);
    @(negedge clk);
    chk_all("gap drop", 1'b0, 1'b1, 1'b0, 90, 1'b0, 1, 1);
    $display("spacing drop: rej=%0b fill=%0d", bus.rej, bus.fill_cnt);

    // Reset one cycle after a done discards the in-flight sample.
    @(negedge clk);
    bus.done = 1'b1; bus.doa = 8'd120; bus.bnum = 6'd4;
    @(negedge clk);
    bus.done = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_all("mid reset", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    reset = 1'b0;
    @(negedge clk);
    chk_all("post reset", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    $display("mid reset: upd=%0b fill=%0d avg=%0d", bus.upd, bus.fill_cnt, bus.avg_doa);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
